// File: rtl/srl_delay_pkg.sv
`default_nettype none
// ============================================================================
// Module  : srl_delay_pkg
// Purpose : Shared width helpers and constants for the srl_delay_line slice.
//           sel_width()  - tap-select width, max(1, ceil(log2(depth)))
//           fill_width() - fill counter width, ceil(log2(depth+1))
// Revision: 1.0 - initial release
// ============================================================================
package srl_delay_pkg;

  localparam int unsigned c_default_width   = 8;
  localparam int unsigned c_default_depth   = 32;
  localparam int unsigned c_default_neg_clk = 0;

  // Width of the tap select; a depth of 1 or 2 still needs one select bit.
  function automatic int unsigned sel_width(input int unsigned depth);
    int unsigned w;
    w = $clog2(depth);
    return (w < 1) ? 1 : w;
  endfunction

  // Width able to hold the values 0..depth inclusive.
  function automatic int unsigned fill_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage : srl_delay_pkg
`default_nettype wire

// File: rtl/srl_delay_store.sv
`default_nettype none
// ============================================================================
// Module  : srl_delay_store
// Purpose : Unreset DEPTH x WIDTH shift array with a tap mux. Holds nothing
//           but the SRL-mappable storage so synthesis can map it to
//           dynamic-length shift primitives.
// Ports   : clk    - clock (falling edge when NEG_CLK=1, else rising)
//           ce     - shift enable
//           d      - word shifted into stage 0
//           eff    - tap index, must already be clamped to DEPTH-1
//           q      - stage[eff]
//           q_last - stage[DEPTH-1] (cascade output)
// Revision: 1.0 - initial release
// ============================================================================
module srl_delay_store
  import srl_delay_pkg::*;
#(
  parameter int unsigned WIDTH   = c_default_width,
  parameter int unsigned DEPTH   = c_default_depth,
  parameter int unsigned NEG_CLK = c_default_neg_clk,
  localparam int unsigned SEL_W  = sel_width(DEPTH)
) (
  input  logic             clk,
  input  logic             ce,
  input  logic [WIDTH-1:0] d,
  input  logic [SEL_W-1:0] eff,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] q_last
);

  logic [WIDTH-1:0] stage_q [DEPTH];
  logic [WIDTH-1:0] stage_d [DEPTH];

  always_comb begin
    stage_d = stage_q;
    if (ce) begin
      stage_d[0] = d;
      for (int k = 1; k < DEPTH; k++) begin
        stage_d[k] = stage_q[k-1];
      end
    end
  end

  // No reset on purpose: a reset would block SRL inference.
  generate
    if (NEG_CLK != 0) begin : g_neg_edge
      always_ff @(negedge clk) begin
        stage_q <= stage_d;
      end
    end else begin : g_pos_edge
      always_ff @(posedge clk) begin
        stage_q <= stage_d;
      end
    end
  endgenerate

  assign q      = stage_q[eff];
  assign q_last = stage_q[DEPTH-1];

endmodule : srl_delay_store
`default_nettype wire

// File: rtl/srl_delay_line.sv
`default_nettype none
// ============================================================================
// Module  : srl_delay_line
// Purpose : Addressable multi-bit delay line. A saturating fill counter
//           qualifies the selected tap so the data storage stays unreset.
// Ports   : clk     - clock; active edge chosen by NEG_CLK
//           r       - synchronous active-high reset of the fill counter
//           ce      - shift enable
//           d       - data shifted into stage 0
//           sel     - tap select, clamped to DEPTH-1; 0 = newest
//           q       - data at the selected tap
//           q_valid - selected tap written since the last reset
//           q_last  - stage DEPTH-1, always unregistered
// Macro   : SRL_DELAY_OREG_EN - when defined, q/q_valid are registered on
//           every active edge (reset to 0), adding one clock of latency.
// Revision: 1.0 - initial release
// ============================================================================
module srl_delay_line
  import srl_delay_pkg::*;
#(
  parameter int unsigned WIDTH   = c_default_width,
  parameter int unsigned DEPTH   = c_default_depth,
  parameter int unsigned NEG_CLK = c_default_neg_clk,
  localparam int unsigned SEL_W  = sel_width(DEPTH),
  localparam int unsigned FILL_W = fill_width(DEPTH)
) (
  input  logic             clk,
  input  logic             r,
  input  logic             ce,
  input  logic [WIDTH-1:0] d,
  input  logic [SEL_W-1:0] sel,
  output logic [WIDTH-1:0] q,
  output logic             q_valid,
  output logic [WIDTH-1:0] q_last
);

  localparam logic [SEL_W-1:0]  c_max_tap  = SEL_W'(DEPTH - 1);
  localparam logic [FILL_W-1:0] c_fill_max = FILL_W'(DEPTH);

  logic [SEL_W-1:0]  eff;
  logic [FILL_W-1:0] fill_q;
  logic [FILL_W-1:0] fill_d;
  logic [WIDTH-1:0]  tap_data;
  logic              tap_valid;

  // sel may address past the last stage when DEPTH is not a power of two.
  assign eff = (sel > c_max_tap) ? c_max_tap : sel;

  // Saturating increment; reset is applied in the flop block.
  always_comb begin
    fill_d = fill_q;
    if (ce && (fill_q != c_fill_max)) begin
      fill_d = fill_q + FILL_W'(1);
    end
  end

  // Tap eff was written once more than eff shifts have occurred.
  assign tap_valid = (fill_q > FILL_W'(eff));

  srl_delay_store #(
    .WIDTH   (WIDTH),
    .DEPTH   (DEPTH),
    .NEG_CLK (NEG_CLK)
  ) u_store (
    .clk    (clk),
    .ce     (ce),
    .d      (d),
    .eff    (eff),
    .q      (tap_data),
    .q_last (q_last)
  );

`ifdef SRL_DELAY_OREG_EN
  logic [WIDTH-1:0] q_q;
  logic             q_valid_q;

  // Output register runs every active edge regardless of ce.
  generate
    if (NEG_CLK != 0) begin : g_neg_edge
      always_ff @(negedge clk) begin
        if (r) begin
          fill_q    <= '0;
          q_q       <= '0;
          q_valid_q <= 1'b0;
        end else begin
          fill_q    <= fill_d;
          q_q       <= tap_data;
          q_valid_q <= tap_valid;
        end
      end
    end else begin : g_pos_edge
      always_ff @(posedge clk) begin
        if (r) begin
          fill_q    <= '0;
          q_q       <= '0;
          q_valid_q <= 1'b0;
        end else begin
          fill_q    <= fill_d;
          q_q       <= tap_data;
          q_valid_q <= tap_valid;
        end
      end
    end
  endgenerate

  assign q       = q_q;
  assign q_valid = q_valid_q;
`else
  generate
    if (NEG_CLK != 0) begin : g_neg_edge
      always_ff @(negedge clk) begin
        if (r) begin
          fill_q <= '0;
        end else begin
          fill_q <= fill_d;
        end
      end
    end else begin : g_pos_edge
      always_ff @(posedge clk) begin
        if (r) begin
          fill_q <= '0;
        end else begin
          fill_q <= fill_d;
        end
      end
    end
  endgenerate

  assign q       = tap_data;
  assign q_valid = tap_valid;
`endif

endmodule : srl_delay_line
`default_nettype wire

// File: tb/tb_srl_delay_line.sv
`default_nettype none
// ============================================================================
// Module  : tb_srl_delay_line
// Purpose : Directed self-checking bench for srl_delay_line. Three instances:
//           DEPTH=32 rising edge, DEPTH=20 rising edge (tap clamp), and
//           DEPTH=2 falling edge. Expectations adapt to SRL_DELAY_OREG_EN.
// Revision: 1.0 - initial release
// ============================================================================
module tb_srl_delay_line;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Shared stimulus for the DEPTH=32 and DEPTH=20 instances
  logic       r, ce;
  logic [7:0] d;
  logic [4:0] sel, sel20;
  logic [7:0] q, q_last, q20, q_last20;
  logic       q_valid, q_valid20;

  // Falling-edge DEPTH=2 instance
  logic       nr, nce, nsel;
  logic [7:0] nd, nq, nq_last;
  logic       nq_valid;

  int n_checks = 0;
  int n_fails  = 0;

  srl_delay_line #(.WIDTH(8), .DEPTH(32), .NEG_CLK(0)) u_dut (
    .clk(clk), .r(r), .ce(ce), .d(d), .sel(sel),
    .q(q), .q_valid(q_valid), .q_last(q_last)
  );

  srl_delay_line #(.WIDTH(8), .DEPTH(20), .NEG_CLK(0)) u_d20 (
    .clk(clk), .r(r), .ce(ce), .d(d), .sel(sel20),
    .q(q20), .q_valid(q_valid20), .q_last(q_last20)
  );

  srl_delay_line #(.WIDTH(8), .DEPTH(2), .NEG_CLK(1)) u_neg (
    .clk(clk), .r(nr), .ce(nce), .d(nd), .sel(nsel),
    .q(nq), .q_valid(nq_valid), .q_last(nq_last)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // With the output register, one idle edge brings q/q_valid up to date
  // without disturbing storage or fill.
  task automatic settle();
    r  = 1'b0;
    ce = 1'b0;
`ifdef SRL_DELAY_OREG_EN
    tick();
`endif
    #1;
  endtask

  task automatic step(input logic rr, input logic cc, input logic [7:0] dd);
    r  = rr;
    ce = cc;
    d  = dd;
    tick();
    settle();
  endtask

  task automatic settle_n();
`ifdef SRL_DELAY_OREG_EN
    @(negedge clk);
    #1;
`endif
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    r = 1'b1; ce = 1'b0; d = 8'h00; sel = 5'd4; sel20 = 5'd31;
    nr = 1'b1; nce = 1'b0; nd = 8'h00; nsel = 1'b0;

    // Reset for two edges
    tick();
    tick();
    r = 1'b0;
    check("rst_valid", 32'(q_valid), 32'd0);
    check("rst_valid20", 32'(q_valid20), 32'd0);
`ifdef SRL_DELAY_OREG_EN
    check("rst_q_oreg", 32'(q), 32'd0);
`endif

    // Fill with 1..20: tap 4 valid from edge 5, DEPTH=20 clamp valid at 20
    for (int i = 1; i <= 20; i++) begin
      step(1'b0, 1'b1, 8'(i));
      if (i < 5) begin
        check("tap4_not_valid", 32'(q_valid), 32'd0);
      end else begin
        check("tap4_valid", 32'(q_valid), 32'd1);
        check("tap4_data", 32'(q), 32'(i - 4));
      end
      if (i < 20) begin
        check("d20_not_valid", 32'(q_valid20), 32'd0);
      end else begin
        check("d20_valid", 32'(q_valid20), 32'd1);
        check("d20_q", 32'(q20), 32'd1);
        check("d20_q_last", 32'(q_last20), 32'd1);
        check("d20_q_eq_last", 32'(q20), 32'(q_last20));
      end
    end

    // ce pattern 1,0,0,1 at tap 0
    sel = 5'd0;
    step(1'b0, 1'b1, 8'd21); check("ce1_q", 32'(q), 32'd21);
    step(1'b0, 1'b0, 8'h55); check("ce0_hold_a", 32'(q), 32'd21);
    step(1'b0, 1'b0, 8'h55); check("ce0_hold_b", 32'(q), 32'd21);
    step(1'b0, 1'b1, 8'd22); check("ce1_again_q", 32'(q), 32'd22);
    // fill must be 22: tap 21 valid (holding word 1), tap 22 not
    sel = 5'd21; settle();
    check("fill22_tap21_valid", 32'(q_valid), 32'd1);
    check("fill22_tap21_q", 32'(q), 32'd1);
    sel = 5'd22; settle();
    check("fill22_tap22_invalid", 32'(q_valid), 32'd0);

    // 40 ce-edges in total; fill saturates at 32
    for (int i = 23; i <= 40; i++) step(1'b0, 1'b1, 8'(i));
    sel = 5'd31; settle();
    check("sat_valid", 32'(q_valid), 32'd1);
    check("sat_q", 32'(q), 32'd9);
    check("sat_q_last", 32'(q_last), 32'd9);

    // Tap change latency: stage[2]=38, stage[5]=35
    sel = 5'd2; settle();
    check("sel2_q", 32'(q), 32'd38);
    sel = 5'd5;
    #1;
`ifdef SRL_DELAY_OREG_EN
    check("sel5_before_edge", 32'(q), 32'd38);
`else
    check("sel5_comb", 32'(q), 32'd35);
`endif
    tick();
    check("sel5_after_edge", 32'(q), 32'd35);

    // Reset together with a shift: storage still shifts
    sel = 5'd0;
    step(1'b1, 1'b1, 8'hA5);
    check("midrst_valid", 32'(q_valid), 32'd0);
    check("midrst_q_shifted", 32'(q), 32'hA5);
    for (int k = 1; k <= 31; k++) begin
      step(1'b0, 1'b1, 8'h00);
      if (k == 1) check("midrst_refill_valid", 32'(q_valid), 32'd1);
    end
    check("midrst_q_last", 32'(q_last), 32'hA5);
    sel = 5'd31; settle();
    check("midrst_tap31_invalid", 32'(q_valid), 32'd0);
    sel = 5'd30; settle();
    check("midrst_tap30_valid", 32'(q_valid), 32'd1);

    // Falling-edge instance (reset has been held over many falling edges)
    @(negedge clk); #1;
    nr = 1'b0;
    settle_n();
    check("neg_rst_valid", 32'(nq_valid), 32'd0);
    nce = 1'b1; nd = 8'h3C;
    @(posedge clk); #1;
    check("neg_rise_no_fill", 32'(nq_valid), 32'd0);
    @(negedge clk); #1;
    nce = 1'b0;
    settle_n();
    check("neg_fall_q", 32'(nq), 32'h3C);
    check("neg_fall_valid", 32'(nq_valid), 32'd1);
    nsel = 1'b1; settle_n();
    check("neg_tap1_invalid", 32'(nq_valid), 32'd0);
    nsel = 1'b0; settle_n();
    nce = 1'b1; nd = 8'h77;
    @(posedge clk); #1;
    check("neg_rise_hold_q", 32'(nq), 32'h3C);
    @(negedge clk); #1;
    nce = 1'b0;
    settle_n();
    check("neg_second_q", 32'(nq), 32'h77);
    check("neg_q_last", 32'(nq_last), 32'h3C);
    nsel = 1'b1; settle_n();
    check("neg_tap1_q", 32'(nq), 32'h3C);
    check("neg_tap1_valid", 32'(nq_valid), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule : tb_srl_delay_line
`default_nettype wire
